// File: rtl/tap_sequencer.sv
// tap_sequencer: walks a tap address through 0..N_TAPS-1 (up) or N_TAPS-1..0
// (down) once per frame. It supports an advance qualifier, looping frames, a
// one-cycle done pulse and a sticky overrun flag for starts that arrive while busy.
module tap_sequencer #(
  parameter  int N_TAPS = 8,
  localparam int AW     = $clog2(N_TAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          en,
  input  logic          dir,
  input  logic          loop,
  input  logic          clr_ovr,
  output logic [AW-1:0] addr,
  output logic          first,
  output logic          last,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  // The top address is computed from N_TAPS, so counting never leaves the
  // legal range when N_TAPS is not a power of two.
  localparam logic [AW-1:0] MAX_ADDR = AW'(N_TAPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  logic [AW-1:0] start_val;
  logic [AW-1:0] end_val;

  // Frame endpoints follow the direction latched at frame start.
  assign start_val = dir_q ? MAX_ADDR : '0;
  assign end_val   = dir_q ? '0 : MAX_ADDR;

  // State register: reset asserts immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic: sequencing, wrap/stop at the end value, and overrun handling.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    // The clear is applied first, so a set in the same cycle takes priority.
    if (clr_ovr) ovr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          dir_d   = dir;
          addr_d  = dir ? MAX_ADDR : '0;
        end
      end
      RUN: begin
        // A start during RUN, including during the exit cycle, never begins a frame.
        if (start) ovr_d = 1'b1;
        if (en) begin
          if (addr_q == end_val) begin
            done_d = 1'b1;
            if (loop) begin
              addr_d = start_val;
            end else begin
              state_d = IDLE;
              addr_d  = '0;
            end
          end else begin
            addr_d = dir_q ? (addr_q - AW'(1)) : (addr_q + AW'(1));
          end
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Output decode: first/last are combinational views of the registered state.
  always_comb begin
    busy    = (state_q == RUN);
    first   = busy && (addr_q == start_val);
    last    = busy && (addr_q == end_val);
    addr    = addr_q;
    done    = done_q;
    overrun = ovr_q;
  end

endmodule

// File: doc/tap_sequencer.md
TAP_SEQUENCER -- requirements
Module: tap_sequencer

Interface
REQ-001 The block SHALL have parameter N_TAPS, default 8, giving the taps per frame; legal range 2..1024.
REQ-002 The block SHALL have derived localparam AW = $clog2(N_TAPS), giving the address width.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port start, input, 1 bit: one-cycle sample strobe that requests a new frame.
REQ-006 Port en, input, 1 bit: advance qualifier; when 0, the address SHALL hold.
REQ-007 Port dir, input, 1 bit: 0 = count up (0 to N_TAPS-1), 1 = count down (N_TAPS-1 to 0); sampled only at frame start.
REQ-008 Port loop, input, 1 bit: 1 = wrap and continue at frame end; 0 = stop at frame end.
REQ-009 Port clr_ovr, input, 1 bit: clears the sticky overrun flag.
REQ-010 Port addr, output, AW bits: current tap address.
REQ-011 Port first, output, 1 bit: high while busy and addr equals the frame start value.
REQ-012 Port last, output, 1 bit: high while busy and addr equals the frame end value.
REQ-013 Port busy, output, 1 bit: high while a frame is in progress.
REQ-014 Port done, output, 1 bit: one-cycle pulse after the last tap is consumed.
REQ-015 Port overrun, output, 1 bit: sticky flag; a start arrived while busy.

Function
REQ-016 The block SHALL have states IDLE and RUN. The registered outputs are addr, busy, done and overrun; first and last SHALL be decoded combinationally from registered state.
REQ-017 IDLE + start=1: next cycle SHALL be state RUN, busy=1, addr = start value (0 if dir=0, N_TAPS-1 if dir=1); the latched direction is held for the whole frame.
REQ-018 Latency: the first tap address SHALL be valid exactly 1 cycle after start; start SHALL be accepted in IDLE regardless of en.
REQ-019 RUN + en=1 + addr != end value: addr SHALL step by +1 (up) or -1 (down).
REQ-020 RUN + en=0: addr, state and flags SHALL hold; done SHALL stay 0.
REQ-021 RUN + en=1 + addr == end value + loop=0: next cycle SHALL be IDLE, busy=0, addr=0, done=1 for exactly one cycle.
REQ-022 RUN + en=1 + addr == end value + loop=1: next cycle SHALL remain RUN, addr = start value of the latched direction, done=1 for one cycle; dir SHALL NOT be re-sampled.
REQ-023 The address SHALL never leave 0..N_TAPS-1, including when N_TAPS is not a power of two.
REQ-024 start=1 while in RUN SHALL be ignored for sequencing and SHALL set overrun=1 on the next cycle.
REQ-025 clr_ovr=1 SHALL clear overrun on the next cycle; if a set condition and clr_ovr occur in the same cycle, set SHALL win.
REQ-026 start=1 in the same cycle that RUN exits to IDLE (end value, en=1, loop=0) SHALL count as an overrun and SHALL NOT start a frame.
REQ-027 loop may be changed mid-frame; it SHALL be evaluated only in the end-value cycle.
REQ-028 In IDLE, done=0 except for the single pulse cycle; first and last SHALL be 0.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for a clk edge, force state IDLE, addr=0, busy=0, done=0 and overrun=0.
REQ-030 Assertion of reset mid-frame SHALL abort the frame with no done pulse.
REQ-031 After reset deasserts, the first start SHALL be accepted on the next clk edge.

Verification (N_TAPS=8 unless stated)
REQ-032 Scenario: start, dir=0, loop=0, en=1 -> addr 0..7 over 8 cycles, first at 0, last at 7, done one cycle after addr=7, then busy=0 and addr=0.
REQ-033 Scenario: start, dir=1, en toggling 1/0 -> addr 7,6,..,0 with each value held while en=0; done asserted only after addr=0 is consumed with en=1.
REQ-034 Scenario: loop=1 for 2 frames then loop=0 -> addr 0..7,0..7, two done pulses, busy stays continuous, then IDLE.
REQ-035 Scenario: start at addr=3 and again at the end-value cycle -> sequence unaffected, overrun=1; clr_ovr together with another start -> overrun remains 1.
REQ-036 Scenario: reset=0 asynchronously at addr=5 -> outputs clear before the next edge and no done pulse follows.
REQ-037 Scenario: N_TAPS=5 (AW=3), up and down -> addr never exceeds 4 and wraps correctly with loop=1.
